// File: rtl/div2_pkg.sv
// Shared multdiv definitions: datapath width, divider FSM states, iteration count.
package div2_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Unsigned magnitude of a two's-complement word; 0x80000000 maps to itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div2_cla.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_grp
      localparam int B0 = 4 * gi;
      // Lookahead carries inside one 4-bit group.
      assign c[B0+1] = g[B0] | (p[B0] & c[B0]);
      assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & c[B0]);
      assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+2] & p[B0+1] & p[B0] & c[B0]);
      assign c[B0+4] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                     | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+3] & p[B0+2] & p[B0+1] & p[B0] & c[B0]);
    end
  endgenerate

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/div2.sv
// Sequential signed 32-bit divider: radix-2 restoring iteration on magnitudes,
// sign fix-up in a final cycle, divide-by-zero answered on the start edge.
module div2
  import div2_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Ordy,
  output logic             exp
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH:0]   r_reg, r_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sa_reg, sa_next;
  logic             sq_reg, sq_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             ordy_reg, ordy_next;
  logic             exp_reg, exp_next;

  logic             start_ok;
  logic             start_dbz;
  logic [WIDTH-1:0] diff_lo;
  logic             diff_cout;
  logic             trial_msb;
  logic             trial_ok;

  assign start_ok  = ctrl_DIV && (B != '0);
  assign start_dbz = ctrl_DIV && (B == '0);

  // Trial subtraction {R[31:0],Q[31]} - {0,D}: low 32 bits through the CLA,
  // bit 32 is R[31] plus the all-ones top bit of ~{0,D} plus the carry.
  CLA_32bit u_cla (
    .a   ({r_reg[WIDTH-2:0], q_reg[WIDTH-1]}),
    .b   (~d_reg),
    .cin (1'b1),
    .sum (diff_lo),
    .cout(diff_cout)
  );

  assign trial_msb = ~(r_reg[WIDTH-1] ^ diff_cout);
  assign trial_ok  = ~trial_msb;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      sa_reg    <= 1'b0;
      sq_reg    <= 1'b0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      ordy_reg  <= 1'b0;
      exp_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      sa_reg    <= sa_next;
      sq_reg    <= sq_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      ordy_reg  <= ordy_next;
      exp_reg   <= exp_next;
    end
  end

  // Next state: a start in any state restarts; RUN exits after the last iteration.
  always_comb begin
    state_next = state_reg;
    if (start_ok) begin
      state_next = RUN;
    end else if (start_dbz) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        RUN:     state_next = (cnt_reg == LAST_ITER) ? FIX : RUN;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and result updates for each state.
  always_comb begin
    q_next    = q_reg;
    d_next    = d_reg;
    r_next    = r_reg;
    cnt_next  = cnt_reg;
    sa_next   = sa_reg;
    sq_next   = sq_reg;
    quo_next  = quo_reg;
    rem_next  = rem_reg;
    exp_next  = exp_reg;
    ordy_next = 1'b0;
    if (start_ok) begin
      q_next   = mag(A);
      d_next   = mag(B);
      r_next   = '0;
      cnt_next = '0;
      sa_next  = A[WIDTH-1];
      sq_next  = A[WIDTH-1] ^ B[WIDTH-1];
    end else if (start_dbz) begin
      quo_next  = '0;
      rem_next  = A;
      exp_next  = 1'b1;
      ordy_next = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (trial_ok) begin
            r_next = {trial_msb, diff_lo};
            q_next = {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            r_next = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
            q_next = {q_reg[WIDTH-2:0], 1'b0};
          end
          cnt_next = cnt_reg + 1'b1;
        end
        FIX: begin
          quo_next  = sq_reg ? (~q_reg + 1'b1) : q_reg;
          rem_next  = sa_reg ? (~r_reg[WIDTH-1:0] + 1'b1) : r_reg[WIDTH-1:0];
          exp_next  = 1'b0;
          ordy_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign Ordy      = ordy_reg;
  assign exp       = exp_reg;

endmodule

// File: tb/tb_div2.sv
// Self-checking bench for div2: directed corner cases plus random operands
// checked against a plain-arithmetic signed division model.
module tb_div2;

  logic        clk;
  logic        clr_n;
  logic        ctrl_DIV;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        Ordy;
  logic        exp;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] prev_q = 32'd0;

  div2 dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .ctrl_DIV (ctrl_DIV),
    .A        (A),
    .B        (B),
    .quotient (quotient),
    .remainder(remainder),
    .Ordy     (Ordy),
    .exp      (exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: truncating signed division in 64-bit arithmetic, results mod 2^32.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb, q64, r64;
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      q   = q64[31:0];
      r   = r64[31:0];
      e   = 1'b0;
    end
  endtask

  // Called at a falling edge: start a divide, then check latency and results.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    logic        ee;
    int          n;
    int          lat;
    ref_div(a, b, eq, er, ee);
    lat = (b == 32'd0) ? 0 : 33;
    A = a;
    B = b;
    ctrl_DIV = 1'b1;
    @(posedge clk);
    #1;
    ctrl_DIV = 1'b0;
    A = $urandom;
    B = $urandom;
    @(negedge clk);
    if (b != 32'd0) chk({tag, "_held"}, quotient, prev_q);
    n = 0;
    while (!Ordy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_exp"}, {31'd0, exp}, {31'd0, ee});
    $display("div a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h exp=%0b lat=%0d",
             a, b, quotient, remainder, exp, n);
    prev_q = eq;
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    clk = 1'b0;
    clr_n = 1'b1;
    ctrl_DIV = 1'b0;
    A = 32'd0;
    B = 32'd0;
    #1 clr_n = 1'b0;
    #1;
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_ordy", {31'd0, Ordy}, 32'd0);
    chk("rst_exp", {31'd0, exp}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    do_div(32'd100, 32'd7, "pos_pos");
    do_div(-32'sd100, 32'd7, "neg_pos");
    do_div(32'd100, -32'sd7, "pos_neg");
    do_div(-32'sd100, -32'sd7, "neg_neg");
    do_div(32'd7, 32'd0, "dbz");
    do_div(32'd9, 32'd3, "after_dbz");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, "min_m1");
    do_div(32'h8000_0000, 32'd1, "min_p1");
    do_div(32'h7FFF_FFFF, 32'h8000_0000, "max_min");
    do_div(32'd0, 32'd5, "zero_div");
    do_div(32'hFFFF_FFF0, 32'd0, "dbz_neg");
    do_div(32'hFFFF_FFF0, 32'd0, "dbz_b2b");

    // Abort: a second start ten cycles in replaces the first operation.
    A = 32'd1000;
    B = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clk);
    #1 ctrl_DIV = 1'b0;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (Ordy) cnt++;
    end
    chk("abort_no_ordy", 32'(cnt), 32'd0);
    do_div(32'd50, 32'd5, "abort_new");

    // Reset mid-operation clears outputs and discards the operation.
    A = 32'd1000;
    B = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clk);
    #1 ctrl_DIV = 1'b0;
    repeat (15) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_quo", quotient, 32'd0);
    chk("midrst_rem", remainder, 32'd0);
    chk("midrst_ordy", {31'd0, Ordy}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Ordy) cnt++;
    end
    chk("midrst_no_ordy", 32'(cnt), 32'd0);
    prev_q = 32'd0;
    do_div(32'd1000, 32'd3, "after_rst");

    // Random operands, including small and zero divisors.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_div(ra, rb, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div2.md
# div2

Sequential 32-bit signed integer divider for the multdiv unit, the counterpart of the radix-4 Booth multiplier. It latches dividend and divisor on a one-cycle `ctrl_DIV` pulse and runs a radix-2 restoring iteration on operand magnitudes, one quotient bit per cycle. It then sign-corrects the result and presents quotient and remainder with a one-cycle ready pulse. Divide-by-zero is flagged through `exp`, matching the multiplier's exception output.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `ctrl_DIV` in 1: start pulse; operands are sampled on the same edge.
- `A` in 32: dividend, two's complement.
- `B` in 32: divisor, two's complement.
- `quotient` out 32: truncated quotient; held until the next start.
- `remainder` out 32: remainder, sign follows the dividend; held until the next start.
- `Ordy` out 1: one-cycle pulse when results are valid.
- `exp` out 1: exception (divide by zero); valid while `Ordy` is high, then held.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `ctrl_DIV`=1 and `B`≠0:
  - latch |A| into Q, |B| into D, and the signs sA and sA^sB;
  - clear the 33-bit partial remainder R;
  - set count=0 and go to RUN.
- IDLE, `ctrl_DIV`=1 and `B`=0: go to IDLE with `quotient`=0, `remainder`=A, `exp`=1, `Ordy`=1.
- RUN, each cycle:
  - T = {R[31:0], Q[31]} − {1'b0, D};
  - if T is non-negative: R=T, Q={Q[30:0],1};
  - otherwise: R={R[31:0],Q[31]}, Q={Q[30:0],0};
  - count++; at count==31 go to FIX.
- FIX:
  - `quotient` = sign ? −Q : Q;
  - `remainder` = sA ? −R[31:0] : R[31:0];
  - `exp`=0, `Ordy`=1, go to IDLE.
- Arithmetic:
  - magnitudes are 32-bit unsigned, so |−2^31| = 0x80000000 is exact;
  - the subtraction is 33-bit;
  - negation is two's complement mod 2^32.
- −2^31 / −1: `quotient` wraps to 0x80000000, `remainder`=0, `exp`=0. No overflow flag.
- `ctrl_DIV` in RUN or FIX aborts the operation in flight and restarts with the new operands. No `Ordy` is produced for the aborted operation.
- `A`/`B` are ignored except on the start edge.

## Timing
- Start edge E0. RUN occupies edges E1..E32; the FIX edge E33 registers the results.
- `Ordy` is high for the cycle after E33: latency 33 clocks.
- Divide-by-zero: results and `Ordy` are registered at E0 itself, so `Ordy` is high in the cycle after E0.
- `Ordy` deasserts on the next edge unless a new divide-by-zero start occurs.
- Back-to-back: `ctrl_DIV` during the `Ordy` cycle starts a new operation. Outputs keep the old result until the new operation's FIX.
- Reset (`clr_n`=0, asynchronous, any state): state=IDLE, count=0, `quotient`=0, `remainder`=0, `Ordy`=0, `exp`=0, all internal registers 0.
  - Mid-operation reset discards the operation.
  - The first start is accepted on the first rising edge after `clr_n` deasserts.

## Structure
- Shared multdiv package:
  - state encoding IDLE/RUN/FIX (2 bits);
  - `WIDTH`=32;
  - count width 5;
  - last-iteration constant 31.
- Trial subtraction reuses `CLA_32bit` plus a carry bit for the 33rd bit. This is the one natural sub-module; no new one is created.
- Registers use the codebase `reg1` style with enable, extended to an async active-low clear.

## Test plan
- A=100, B=7, start: `Ordy` 33 cycles later; `quotient`=14, `remainder`=2, `exp`=0.
- A=−100, B=7: `quotient`=−14 (0xFFFFFFF2), `remainder`=−2. A=100, B=−7: `quotient`=−14, `remainder`=2.
- A=7, B=0: `Ordy` in the cycle after the start edge; `exp`=1, `quotient`=0, `remainder`=7. The next valid divide has `exp`=0.
- A=0x80000000, B=0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0, `exp`=0. A=0x80000000, B=1: `quotient`=0x80000000.
- Start 1000/3, then start 50/5 at cycle 10: exactly one `Ordy`, 33 cycles after the second start, with `quotient`=10, `remainder`=0.
- Start 1000/3, assert `clr_n`=0 at cycle 15: outputs clear immediately and no `Ordy` follows. A start after release gives 333 r1.
